// File: rtl/stream_chk_pkg.sv
// Shared constants for the counting-stream checker: state encoding,
// default parameters and statistics counter widths.
package stream_chk_pkg;

  localparam logic ST_ACQ    = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  typedef enum logic {
    S_ACQ    = ST_ACQ,
    S_LOCKED = ST_LOCKED
  } chk_state_e;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_LOCK_LEN = 4;
  localparam int unsigned DEF_LOSE_LEN = 3;

  localparam int unsigned ERR_CNT_W   = 8;
  localparam int unsigned MATCH_CNT_W = 16;

endpackage

// File: rtl/stream_seq_checker_sat_counter.sv
// Saturating up-counter with async reset and synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/stream_seq_checker.sv
// Receive-side checker for a free-running +1 counting stream: acquires lock on a
// chain of increments, then flywheels the expected value and records mismatches.
module stream_seq_checker
  import stream_chk_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LOCK_LEN = DEF_LOCK_LEN,
  parameter int unsigned LOSE_LEN = DEF_LOSE_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [WIDTH-1:0]       rx_data,
  input  logic                   clr,
  output logic                   locked,
  output logic                   err_pulse,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic [MATCH_CNT_W-1:0] match_cnt,
  output logic [WIDTH-1:0]       last_exp,
  output logic [WIDTH-1:0]       last_got
);

  localparam int unsigned RUN_W  = $clog2(LOCK_LEN + 1);
  localparam int unsigned MISS_W = $clog2(LOSE_LEN + 1);

  chk_state_e        state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [WIDTH-1:0]  last_exp_q, last_exp_d;
  logic [WIDTH-1:0]  last_got_q, last_got_d;
  logic              err_pulse_q, err_pulse_d;
  logic              err_inc;
  logic              match_inc;
  logic [WIDTH-1:0]  exp_val;

  assign exp_val = prev_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    run_d       = run_q;
    miss_d      = miss_q;
    last_exp_d  = last_exp_q;
    last_got_d  = last_got_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    match_inc   = 1'b0;
    if (en && !clr) begin
      case (state_q)
        S_ACQ: begin
          if (!have_prev_q || (rx_data != exp_val)) begin
            run_d = RUN_W'(1);
          end else begin
            run_d = run_q + 1'b1;
          end
          prev_d      = rx_data;
          have_prev_d = 1'b1;
          if (run_d == RUN_W'(LOCK_LEN)) begin
            state_d = S_LOCKED;
            miss_d  = '0;
          end
        end
        S_LOCKED: begin
          // Flywheel: the reference advances regardless of what arrived.
          prev_d = exp_val;
          if (rx_data == exp_val) begin
            match_inc = 1'b1;
            miss_d    = '0;
          end else begin
            err_inc     = 1'b1;
            err_pulse_d = 1'b1;
            last_exp_d  = exp_val;
            last_got_d  = rx_data;
            miss_d      = miss_q + 1'b1;
            if (miss_d == MISS_W'(LOSE_LEN)) begin
              state_d     = S_ACQ;
              run_d       = '0;
              have_prev_d = 1'b0;
            end
          end
        end
        default: state_d = S_ACQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ACQ;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      run_q       <= '0;
      miss_q      <= '0;
      last_exp_q  <= '0;
      last_got_q  <= '0;
      err_pulse_q <= 1'b0;
    end else if (clr) begin
      state_q     <= S_ACQ;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      run_q       <= '0;
      miss_q      <= '0;
      last_exp_q  <= '0;
      last_got_q  <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      last_exp_q  <= last_exp_d;
      last_got_q  <= last_got_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  sat_counter #(.WIDTH(ERR_CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_inc),
    .q   (err_cnt)
  );

  sat_counter #(.WIDTH(MATCH_CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (match_inc),
    .q   (match_cnt)
  );

  assign locked    = (state_q == S_LOCKED);
  assign err_pulse = err_pulse_q;
  assign last_exp  = last_exp_q;
  assign last_got  = last_got_q;

endmodule
